log_compress_top: RTL and testbench
===================================

Name: log_compress_top

Overview:
- Log-compression stage of the ultrasound receive chain.
- Consumes envelope/power samples popped from an upstream FIFO and produces a fixed-point log2 value per sample, using Mitchell approximation: leading-one position gives the integer part, bits below it give the fraction.
- Fully pipelined, one sample per cycle.
- Sits between the sample FIFO (whose rd_en it drives) and display/scan-conversion logic.

Parameters:
- DATA_WIDTH, 48, width of the unsigned input sample.
- COMP_WIDTH, 24, width of the compressed output; must be greater than IW.
- IW (localparam), $clog2(DATA_WIDTH) = 6, integer bits of comp_out.
- FW (localparam), COMP_WIDTH-IW = 18, fraction bits of comp_out.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- data_in  in  DATA_WIDTH  unsigned sample from the FIFO; valid when fifo_out_valid=1.
- fifo_out_valid  in  1  data_in holds a popped sample this cycle.
- pre_in_ready  out  1  read-enable to the FIFO; block can accept a sample.
- comp_out  out  COMP_WIDTH  log2(sample), unsigned fixed point: IW integer bits above FW fraction bits.
- comp_valid  out  1  one-cycle strobe; comp_out holds a new result.

Behaviour:
- Reset (reset=0, asynchronous):
  - pre_in_ready=0, comp_out=0, comp_valid=0.
  - All pipeline valids and data registers clear.
  - Any in-flight samples are discarded, including on reset mid-stream.
- pre_in_ready:
  - Registered; rises at the first rising clk edge after reset deasserts.
  - Stays 1 thereafter, since there is no downstream backpressure.
- Acceptance:
  - A sample is accepted on any rising edge where pre_in_ready=1 and fifo_out_valid=1.
  - When fifo_out_valid=0, data_in is ignored and no strobe results.
- Pipeline (3 register stages, throughput 1/cycle, bubbles preserved):
  - S1: register data_in and valid.
  - S2: find leading-one index k (0..DATA_WIDTH-1) of x; set zero flag z=(x==0); normalise m = x << (DATA_WIDTH-1-k).
  - S3: comp_out = {k[IW-1:0], m[DATA_WIDTH-2 -: FW]}. The fraction is the FW bits immediately below the leading one, left-aligned. Missing low bits are zero-filled; extra low bits are truncated with no rounding.
  - If z=1, comp_out=0.
  - comp_valid=1 for exactly one cycle.
- Latency:
  - A sample accepted at edge N appears on comp_out with comp_valid=1 after edge N+3.
- Output hold:
  - comp_out holds its last value when no new result arrives.
  - comp_valid=0 on idle cycles.
- Zero vs one:
  - x=0 and x=1 both yield comp_out=0, by design.
  - Downstream treats 0 as the floor.
- Arithmetic is purely unsigned; no saturation is needed.
  - Maximum output is {DATA_WIDTH-1, all-ones fraction} = 0xBFFFFF at defaults.

Test Plan:
- Reset: hold reset=0 with fifo_out_valid=1 and toggling data -> pre_in_ready=0, comp_valid=0, comp_out=0. Release reset -> pre_in_ready=1 after the next edge.
- Single samples, one per 5 cycles, with checks at default parameters:
  - x=2 -> 0x040000
  - x=3 -> 0x060000
  - x=6 -> 0x0A0000
  - x=0x1000 -> 0x300000
  - x=2^47 -> 0xBC0000
  - x=48'hFFFF_FFFF_FFFF -> 0xBFFFFF
  - Each result has comp_valid high exactly 3 edges after acceptance.
- Zero/one: x=0 -> 0x000000; x=1 -> 0x000000; comp_valid strobes for both.
- Streaming: 30 back-to-back random samples through a FIFO with wr_en=1, rd_en=pre_in_ready -> 30 comp_valid strobes in order, each matching the Mitchell reference model. Gaps in fifo_out_valid produce matching gaps in comp_valid.
- Reset mid-stream: assert reset with 2 samples in flight -> outputs clear immediately, no stale strobe after release. The first post-reset sample has 3-cycle latency.
- Idle hold: after a result, hold fifo_out_valid=0 for 10 cycles -> comp_out unchanged, comp_valid=0.

Source files
------------

// File: rtl/log_compress_top.sv
// Log-compression stage: fixed-point log2 of each popped FIFO sample using the
// Mitchell approximation (leading-one index = integer part, bits below = fraction).
module log_compress_top #(
   parameter int DATA_WIDTH = 48,
   parameter int COMP_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_out_valid,
   output logic                  pre_in_ready,
   output logic [COMP_WIDTH-1:0] comp_out,
   output logic                  comp_valid
);

   localparam int IW = $clog2(DATA_WIDTH);
   localparam int FW = COMP_WIDTH - IW;

   logic                  accept;

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_data;

   logic [IW-1:0]         lod_k;
   logic                  lod_z;

   logic                  s2_valid;
   logic                  s2_z;
   logic [IW-1:0]         s2_k;
   logic [DATA_WIDTH-1:0] s2_x;

   logic [FW-1:0]         frac_next;

   logic                  s3_valid;
   logic                  s3_z;
   logic [IW-1:0]         s3_k;
   logic [FW-1:0]         s3_frac;

   always_comb begin
      accept = pre_in_ready & fifo_out_valid;
   end

   // Priority encode: the highest set bit wins because it is written last.
   always_comb begin
      lod_k = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (s1_data[i]) begin
            lod_k = IW'(i);
         end
      end
      lod_z = (s1_data == '0);
   end

   // (x * 2^FW) >> k equals the left-normalised mantissa with the leading one
   // dropped: the low FW bits are the fraction, zero-filled or truncated as needed.
   always_comb begin
      frac_next = FW'({s2_x, {FW{1'b0}}} >> s2_k);
   end

   // Leading-one detect and normalising shift sit in separate stages so the
   // wide priority encoder and barrel shifter never share a register-to-register path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_in_ready <= 1'b0;
         s1_valid     <= 1'b0;
         s1_data      <= '0;
         s2_valid     <= 1'b0;
         s2_z         <= 1'b0;
         s2_k         <= '0;
         s2_x         <= '0;
         s3_valid     <= 1'b0;
         s3_z         <= 1'b0;
         s3_k         <= '0;
         s3_frac      <= '0;
         comp_valid   <= 1'b0;
         comp_out     <= '0;
      end else begin
         pre_in_ready <= 1'b1;

         s1_valid <= accept;
         if (accept) begin
            s1_data <= data_in;
         end

         s2_valid <= s1_valid;
         s2_z     <= lod_z;
         s2_k     <= lod_k;
         s2_x     <= s1_data;

         s3_valid <= s2_valid;
         s3_z     <= s2_z;
         s3_k     <= s2_k;
         s3_frac  <= frac_next;

         comp_valid <= s3_valid;
         if (s3_valid) begin
            comp_out <= s3_z ? '0 : {s3_k, s3_frac};
         end
      end
   end

endmodule

// File: tb/tb_log_compress_top.sv
// Bench for log_compress_top: arithmetic log2 reference, per-cycle scoreboard
// comparison and directed literal checks.
module tb_log_compress_top;

   localparam int DW = 48;
   localparam int CW = 24;
   localparam int FW = 18;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          fifo_out_valid = 1'b0;
   logic          pre_in_ready;
   logic [CW-1:0] comp_out;
   logic          comp_valid;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [CW-1:0] val;
      int            due;
   } exp_t;

   exp_t          q[$];
   int            cyc = 0;
   logic          ready_m = 1'b0;
   logic [CW-1:0] last_exp = '0;
   int            strobes = 0;

   log_compress_top #(
      .DATA_WIDTH(DW),
      .COMP_WIDTH(CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .fifo_out_valid(fifo_out_valid),
      .pre_in_ready  (pre_in_ready),
      .comp_out      (comp_out),
      .comp_valid    (comp_valid)
   );

   always #5 clk = ~clk;

   // floor(log2 x) in the integer field, (x - 2^k) / 2^k scaled to FW bits below.
   function automatic logic [CW-1:0] mitchell(input logic [DW-1:0] x);
      longint unsigned v;
      longint unsigned rem;
      longint unsigned frac;
      int k;
      v = 64'(x);
      if (v == 0) return '0;
      k = 0;
      while ((v >> (k + 1)) != 0) k++;
      rem = v - (64'd1 << k);
      if (k >= FW) frac = rem >> (k - FW);
      else         frac = rem << (FW - k);
      return CW'((64'(k) << FW) | frac);
   endfunction

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: acceptance needs a ready that rose one edge after reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         ready_m <= 1'b0;
      end else begin
         if (ready_m && fifo_out_valid)
            q.push_back('{mitchell(data_in), cyc + 3});
         ready_m <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         last_exp = '0;
         check("rst_ready", CW'(pre_in_ready), '0);
         check("rst_valid", CW'(comp_valid), '0);
         check("rst_out", comp_out, '0);
      end else begin
         check("ready", CW'(pre_in_ready), CW'(ready_m));
         if (q.size() > 0 && q[0].due == cyc - 1) begin
            check("strobe", CW'(comp_valid), CW'(1));
            check("result", comp_out, q[0].val);
            last_exp = q[0].val;
            void'(q.pop_front());
            strobes++;
         end else begin
            check("idle_valid", CW'(comp_valid), '0);
            check("hold", comp_out, last_exp);
         end
      end
   end

   task automatic send_single(input logic [DW-1:0] x, input logic [CW-1:0] req, input string name);
      @(negedge clk);
      data_in = x;
      fifo_out_valid = 1'b1;
      @(negedge clk);
      fifo_out_valid = 1'b0;
      data_in = {$urandom(), $urandom()};
      repeat (2) @(negedge clk);
      check({name, "_early"}, CW'(comp_valid), '0);
      @(negedge clk);
      check({name, "_valid"}, CW'(comp_valid), CW'(1));
      check(name, comp_out, req);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int s0;
      logic [DW-1:0] r;

      check("model_2",    mitchell(48'd2),          24'h040000);
      check("model_6",    mitchell(48'd6),          24'h0A0000);
      check("model_2p47", mitchell(48'h8000_0000_0000), 24'hBC0000);
      check("model_max",  mitchell(48'hFFFF_FFFF_FFFF), 24'hBFFFFF);
      check("model_5",    mitchell(48'd5),          24'h090000);

      repeat (4) begin
         @(negedge clk);
         fifo_out_valid = 1'b1;
         data_in = {$urandom(), $urandom()};
      end
      check("hold_rst_ready", CW'(pre_in_ready), '0);
      check("hold_rst_valid", CW'(comp_valid), '0);
      check("hold_rst_out", comp_out, '0);
      #2;
      reset = 1'b1;
      fifo_out_valid = 1'b0;
      @(negedge clk);
      check("ready_after_release", CW'(pre_in_ready), CW'(1));

      send_single(48'd2,              24'h040000, "x2");
      send_single(48'd3,              24'h060000, "x3");
      send_single(48'd6,              24'h0A0000, "x6");
      send_single(48'h1000,           24'h300000, "x1000");
      send_single(48'h8000_0000_0000, 24'hBC0000, "x2p47");
      send_single(48'hFFFF_FFFF_FFFF, 24'hBFFFFF, "xmax");
      send_single(48'd0,              24'h000000, "x0");
      send_single(48'd1,              24'h000000, "x1");

      send_single(48'd3,              24'h060000, "pre_idle");
      repeat (10) @(negedge clk);
      check("idle_hold_out", comp_out, 24'h060000);
      check("idle_hold_valid", CW'(comp_valid), '0);

      n = 0;
      s0 = strobes;
      for (int i = 0; n < 30; i++) begin
         @(negedge clk);
         if (i % 9 == 4) begin
            fifo_out_valid = 1'b0;
         end else begin
            r = {$urandom(), $urandom()};
            data_in = r >> $urandom_range(0, 47);
            fifo_out_valid = 1'b1;
            n++;
         end
      end
      @(negedge clk);
      fifo_out_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("stream_count", CW'(strobes - s0), CW'(30));

      @(negedge clk);
      data_in = 48'h0000_00AB_CDEF;
      fifo_out_valid = 1'b1;
      @(negedge clk);
      data_in = 48'h1234_5678_9ABC;
      @(negedge clk);
      fifo_out_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_out", comp_out, '0);
      check("midrst_valid", CW'(comp_valid), '0);
      check("midrst_ready", CW'(pre_in_ready), '0);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_quiet_out", comp_out, '0);
      send_single(48'd6, 24'h0A0000, "post_rst");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
